// File: rtl/rs_pkg.sv
// Shared definitions for the reservation station and its execution units:
// opcode encoding, the "no dependency" tag value, and operand/result records.
package rs_pkg;

  typedef enum logic [5:0] {
    OP_LUI   = 6'd0,
    OP_AUIPC = 6'd1,
    OP_JAL   = 6'd2,
    OP_JALR  = 6'd3,
    OP_BEQ   = 6'd4,
    OP_BNE   = 6'd5,
    OP_BLT   = 6'd6,
    OP_BGE   = 6'd7,
    OP_BLTU  = 6'd8,
    OP_BGEU  = 6'd9,
    OP_ADD   = 6'd10,
    OP_SUB   = 6'd11,
    OP_SLL   = 6'd12,
    OP_SLT   = 6'd13,
    OP_SLTU  = 6'd14,
    OP_XOR   = 6'd15,
    OP_SRL   = 6'd16,
    OP_SRA   = 6'd17,
    OP_OR    = 6'd18,
    OP_AND   = 6'd19,
    OP_ADDI  = 6'd20,
    OP_SLTI  = 6'd21,
    OP_SLTIU = 6'd22,
    OP_XORI  = 6'd23,
    OP_ORI   = 6'd24,
    OP_ANDI  = 6'd25,
    OP_SLLI  = 6'd26,
    OP_SRLI  = 6'd27,
    OP_SRAI  = 6'd28
  } rs_op_e;

  // Tag value meaning "operand value is already present".
  localparam int NON_DEP = 0;

  // Everything an execution unit needs to evaluate one micro-op.
  typedef struct packed {
    rs_op_e      op;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] vj;
    logic [31:0] vk;
  } rs_operands_t;

  // What an execution unit hands back.
  typedef struct packed {
    logic [31:0] result;
    logic        jump;
    logic [31:0] pc_next;
  } rs_result_t;

endpackage

// File: rtl/rs_alu.sv
// Combinational integer ALU / branch resolver for RV32I ALU, jump and branch
// micro-ops. Shift amounts use the low 5 bits of the second operand.
module rs_alu
  import rs_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] vj_i,
  input  logic [31:0] vk_i,
  output logic [31:0] result_o,
  output logic        jump_o,
  output logic [31:0] pc_next_o
);

  rs_op_e      op;
  logic [31:0] pc_plus4;
  logic [31:0] pc_plus_imm;
  logic [31:0] jalr_tgt;
  logic        eq;
  logic        lt;
  logic        ltu;
  logic        lti;
  logic        ltiu;
  logic        br_take;

  assign op          = rs_op_e'(op_i);
  assign pc_plus4    = pc_i + 32'd4;
  assign pc_plus_imm = pc_i + imm_i;
  assign jalr_tgt    = (vj_i + imm_i) & ~32'd1;
  assign eq          = (vj_i == vk_i);
  assign lt          = ($signed(vj_i) < $signed(vk_i));
  assign ltu         = (vj_i < vk_i);
  assign lti         = ($signed(vj_i) < $signed(imm_i));
  assign ltiu        = (vj_i < imm_i);

  // Branch condition evaluation.
  always_comb begin
    br_take = 1'b0;
    case (op)
      OP_BEQ:  br_take = eq;
      OP_BNE:  br_take = !eq;
      OP_BLT:  br_take = lt;
      OP_BGE:  br_take = !lt;
      OP_BLTU: br_take = ltu;
      OP_BGEU: br_take = !ltu;
      default: br_take = 1'b0;
    endcase
  end

  // Result, jump flag and next PC per opcode; non-jump ops fall through to pc+4.
  always_comb begin
    result_o  = '0;
    jump_o    = 1'b0;
    pc_next_o = pc_plus4;
    case (op)
      OP_LUI:   result_o = imm_i;
      OP_AUIPC: result_o = pc_plus_imm;
      OP_JAL: begin
        result_o  = pc_plus4;
        jump_o    = 1'b1;
        pc_next_o = pc_plus_imm;
      end
      OP_JALR: begin
        result_o  = pc_plus4;
        jump_o    = 1'b1;
        pc_next_o = jalr_tgt;
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        jump_o    = br_take;
        pc_next_o = br_take ? pc_plus_imm : pc_plus4;
      end
      OP_ADD:   result_o = vj_i + vk_i;
      OP_SUB:   result_o = vj_i - vk_i;
      OP_SLL:   result_o = vj_i << vk_i[4:0];
      OP_SLT:   result_o = {31'd0, lt};
      OP_SLTU:  result_o = {31'd0, ltu};
      OP_XOR:   result_o = vj_i ^ vk_i;
      OP_SRL:   result_o = vj_i >> vk_i[4:0];
      OP_SRA:   result_o = $signed(vj_i) >>> vk_i[4:0];
      OP_OR:    result_o = vj_i | vk_i;
      OP_AND:   result_o = vj_i & vk_i;
      OP_ADDI:  result_o = vj_i + imm_i;
      OP_SLTI:  result_o = {31'd0, lti};
      OP_SLTIU: result_o = {31'd0, ltiu};
      OP_XORI:  result_o = vj_i ^ imm_i;
      OP_ORI:   result_o = vj_i | imm_i;
      OP_ANDI:  result_o = vj_i & imm_i;
      OP_SLLI:  result_o = vj_i << imm_i[4:0];
      OP_SRLI:  result_o = vj_i >> imm_i[4:0];
      OP_SRAI:  result_o = $signed(vj_i) >>> imm_i[4:0];
      default:  result_o = '0;
    endcase
  end

endmodule

// File: rtl/rs_age_issue.sv
// Age-ordered reservation station for ALU/branch micro-ops. Entries wake from
// the external CDBs and from this block's own result bus, the oldest ready
// entry issues each cycle through rs_alu, and the result is registered onto
// cdb_out for one cycle.
//
// Dispatch handshake: a micro-op transfers on a rising edge where
// dsp_valid && dsp_ready && rdy. dsp_ready depends only on registered
// occupancy, never on dsp_valid, and a refused op must be held by the sender.
module rs_age_issue
  import rs_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int ROB_W   = 4,
  parameter int CDB_NUM = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     dsp_valid,
  output logic                     dsp_ready,
  input  logic [5:0]               dsp_op,
  input  logic [31:0]              dsp_pc,
  input  logic [31:0]              dsp_imm,
  input  logic [31:0]              dsp_vj,
  input  logic [31:0]              dsp_vk,
  input  logic [ROB_W-1:0]         dsp_qj,
  input  logic [ROB_W-1:0]         dsp_qk,
  input  logic [ROB_W-1:0]         dsp_rob,
  input  logic [CDB_NUM-1:0]       cdb_in_valid,
  input  logic [CDB_NUM*ROB_W-1:0] cdb_in_rob,
  input  logic [CDB_NUM*32-1:0]    cdb_in_value,
  output logic                     cdb_out_valid,
  output logic [ROB_W-1:0]         cdb_out_rob,
  output logic [31:0]              cdb_out_value,
  output logic                     cdb_out_jump,
  output logic [31:0]              cdb_out_pc_next,
  input  logic                     flush,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  // Bus 0 is our own result bus, buses 1..CDB_NUM are cdb_in[0..CDB_NUM-1];
  // lower index wins when several buses carry the same tag.
  localparam int NB    = CDB_NUM + 1;

  // Entry storage.
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [5:0]       op_q  [DEPTH];
  logic [5:0]       op_d  [DEPTH];
  logic [31:0]      pc_q  [DEPTH];
  logic [31:0]      pc_d  [DEPTH];
  logic [31:0]      imm_q [DEPTH];
  logic [31:0]      imm_d [DEPTH];
  logic [31:0]      vj_q  [DEPTH];
  logic [31:0]      vj_d  [DEPTH];
  logic [31:0]      vk_q  [DEPTH];
  logic [31:0]      vk_d  [DEPTH];
  logic [ROB_W-1:0] qj_q  [DEPTH];
  logic [ROB_W-1:0] qj_d  [DEPTH];
  logic [ROB_W-1:0] qk_q  [DEPTH];
  logic [ROB_W-1:0] qk_d  [DEPTH];
  logic [ROB_W-1:0] rob_q [DEPTH];
  logic [ROB_W-1:0] rob_d [DEPTH];
  // age_q[i][j] = 1: entry i was allocated before entry j.
  logic [DEPTH-1:0] age_q [DEPTH];
  logic [DEPTH-1:0] age_d [DEPTH];

  logic [CNT_W-1:0] count_q, count_d;

  // Result bus registers.
  logic             out_valid_q, out_valid_d;
  logic [ROB_W-1:0] out_rob_q, out_rob_d;
  logic [31:0]      out_value_q, out_value_d;
  logic             out_jump_q, out_jump_d;
  logic [31:0]      out_pc_next_q, out_pc_next_d;

  // Flattened broadcast buses.
  logic [NB-1:0]       bus_v;
  logic [NB*ROB_W-1:0] bus_t;
  logic [NB*32-1:0]    bus_d;

  // Tag lookups: bit 32 = hit, bits 31:0 = bus value.
  logic [32:0] lk_j [DEPTH];
  logic [32:0] lk_k [DEPTH];
  logic [32:0] lk_dj;
  logic [32:0] lk_dk;

  logic [DEPTH-1:0] ready;
  logic [DEPTH-1:0] older_ready;
  logic             issue_any;
  logic [IDX_W-1:0] issue_idx;
  logic             free_any;
  logic [IDX_W-1:0] free_idx;
  logic             alloc;

  rs_operands_t iss;
  rs_result_t   res;

  // Highest-priority bus carrying a given non-zero tag.
  function automatic logic [32:0] lookup(input logic [ROB_W-1:0]    tag,
                                         input logic [NB-1:0]       v,
                                         input logic [NB*ROB_W-1:0] t,
                                         input logic [NB*32-1:0]    d);
    logic [32:0] r;
    r = '0;
    for (int b = NB - 1; b >= 0; b--) begin
      if (v[b] && (t[b*ROB_W +: ROB_W] == tag) && (tag != ROB_W'(NON_DEP))) begin
        r = {1'b1, d[b*32 +: 32]};
      end
    end
    return r;
  endfunction

  assign bus_v = {cdb_in_valid, out_valid_q};
  assign bus_t = {cdb_in_rob, out_rob_q};
  assign bus_d = {cdb_in_value, out_value_q};

  assign full      = (count_q == CNT_W'(DEPTH));
  assign dsp_ready = !full;
  assign count     = count_q;
  assign alloc     = dsp_valid && !full && free_any;

  assign cdb_out_valid   = out_valid_q;
  assign cdb_out_rob     = out_rob_q;
  assign cdb_out_value   = out_value_q;
  assign cdb_out_jump    = out_jump_q;
  assign cdb_out_pc_next = out_pc_next_q;

  // Operand wake-up and dispatch bypass lookups against every bus.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      lk_j[i] = lookup(qj_q[i], bus_v, bus_t, bus_d);
      lk_k[i] = lookup(qk_q[i], bus_v, bus_t, bus_d);
    end
    lk_dj = lookup(dsp_qj, bus_v, bus_t, bus_d);
    lk_dk = lookup(dsp_qk, bus_v, bus_t, bus_d);
  end

  // Ready vector and, per entry, whether some older entry is also ready.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = busy_q[i] && (qj_q[i] == ROB_W'(NON_DEP)) && (qk_q[i] == ROB_W'(NON_DEP));
    end
    for (int i = 0; i < DEPTH; i++) begin
      older_ready[i] = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        if (ready[j] && age_q[j][i]) older_ready[i] = 1'b1;
      end
    end
  end

  // Pick the oldest ready entry and the lowest-index free entry.
  always_comb begin
    issue_any = 1'b0;
    issue_idx = '0;
    free_any  = 1'b0;
    free_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && !older_ready[i] && !issue_any) begin
        issue_any = 1'b1;
        issue_idx = IDX_W'(i);
      end
      if (!busy_q[i] && !free_any) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign iss = '{op:  rs_op_e'(op_q[issue_idx]),
                 pc:  pc_q[issue_idx],
                 imm: imm_q[issue_idx],
                 vj:  vj_q[issue_idx],
                 vk:  vk_q[issue_idx]};

  rs_alu u_alu (
    .op_i      (iss.op),
    .pc_i      (iss.pc),
    .imm_i     (iss.imm),
    .vj_i      (iss.vj),
    .vk_i      (iss.vk),
    .result_o  (res.result),
    .jump_o    (res.jump),
    .pc_next_o (res.pc_next)
  );

  // Next state: flush wipes occupancy; otherwise wake, issue and allocate.
  always_comb begin
    busy_d        = busy_q;
    op_d          = op_q;
    pc_d          = pc_q;
    imm_d         = imm_q;
    vj_d          = vj_q;
    vk_d          = vk_q;
    qj_d          = qj_q;
    qk_d          = qk_q;
    rob_d         = rob_q;
    age_d         = age_q;
    count_d       = count_q;
    out_valid_d   = 1'b0;
    out_rob_d     = out_rob_q;
    out_value_d   = out_value_q;
    out_jump_d    = out_jump_q;
    out_pc_next_d = out_pc_next_q;
    if (flush) begin
      busy_d  = '0;
      count_d = '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy_q[i] && lk_j[i][32]) begin
          vj_d[i] = lk_j[i][31:0];
          qj_d[i] = ROB_W'(NON_DEP);
        end
        if (busy_q[i] && lk_k[i][32]) begin
          vk_d[i] = lk_k[i][31:0];
          qk_d[i] = ROB_W'(NON_DEP);
        end
      end
      if (issue_any) begin
        busy_d[issue_idx] = 1'b0;
        out_valid_d       = 1'b1;
        out_rob_d         = rob_q[issue_idx];
        out_value_d       = res.result;
        out_jump_d        = res.jump;
        out_pc_next_d     = res.pc_next;
      end
      if (alloc) begin
        busy_d[free_idx] = 1'b1;
        op_d[free_idx]   = dsp_op;
        pc_d[free_idx]   = dsp_pc;
        imm_d[free_idx]  = dsp_imm;
        rob_d[free_idx]  = dsp_rob;
        vj_d[free_idx]   = lk_dj[32] ? lk_dj[31:0] : dsp_vj;
        qj_d[free_idx]   = lk_dj[32] ? ROB_W'(NON_DEP) : dsp_qj;
        vk_d[free_idx]   = lk_dk[32] ? lk_dk[31:0] : dsp_vk;
        qk_d[free_idx]   = lk_dk[32] ? ROB_W'(NON_DEP) : dsp_qk;
        age_d[free_idx]  = '0;
        for (int j = 0; j < DEPTH; j++) begin
          if (busy_q[j]) age_d[j][free_idx] = 1'b1;
        end
      end
      if (alloc && !issue_any) begin
        count_d = count_q + CNT_W'(1);
      end else if (!alloc && issue_any) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // State registers: reset clears everything, rdy low freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q        <= '0;
      op_q          <= '{default: '0};
      pc_q          <= '{default: '0};
      imm_q         <= '{default: '0};
      vj_q          <= '{default: '0};
      vk_q          <= '{default: '0};
      qj_q          <= '{default: '0};
      qk_q          <= '{default: '0};
      rob_q         <= '{default: '0};
      age_q         <= '{default: '0};
      count_q       <= '0;
      out_valid_q   <= 1'b0;
      out_rob_q     <= '0;
      out_value_q   <= '0;
      out_jump_q    <= 1'b0;
      out_pc_next_q <= '0;
    end else if (rdy) begin
      busy_q        <= busy_d;
      op_q          <= op_d;
      pc_q          <= pc_d;
      imm_q         <= imm_d;
      vj_q          <= vj_d;
      vk_q          <= vk_d;
      qj_q          <= qj_d;
      qk_q          <= qk_d;
      rob_q         <= rob_d;
      age_q         <= age_d;
      count_q       <= count_d;
      out_valid_q   <= out_valid_d;
      out_rob_q     <= out_rob_d;
      out_value_q   <= out_value_d;
      out_jump_q    <= out_jump_d;
      out_pc_next_q <= out_pc_next_d;
    end
  end

endmodule

// File: tb/tb_rs_age_issue.sv
// Directed bench for rs_age_issue: stimulus pushes expected CDB results
// {rob, value, jump, pc_next} into exp_q in expected issue order, and a
// negedge monitor pops and compares every cdb_out_valid cycle.
module tb_rs_age_issue;
  import rs_pkg::*;

  localparam int W = 4 + 32 + 1 + 32;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        dsp_valid;
  logic        dsp_ready;
  logic [5:0]  dsp_op;
  logic [31:0] dsp_pc;
  logic [31:0] dsp_imm;
  logic [31:0] dsp_vj;
  logic [31:0] dsp_vk;
  logic [3:0]  dsp_qj;
  logic [3:0]  dsp_qk;
  logic [3:0]  dsp_rob;
  logic [1:0]  cdb_in_valid;
  logic [7:0]  cdb_in_rob;
  logic [63:0] cdb_in_value;
  logic        cdb_out_valid;
  logic [3:0]  cdb_out_rob;
  logic [31:0] cdb_out_value;
  logic        cdb_out_jump;
  logic [31:0] cdb_out_pc_next;
  logic        flush;
  logic        full;
  logic [4:0]  count;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_got;
  logic [W-1:0] mon_exp;
  int vectors;
  int miscompares;

  // ALU vector table, dispatched back to back with no dependencies.
  logic [5:0]  t_op  [9];
  logic [31:0] t_pc  [9];
  logic [31:0] t_imm [9];
  logic [31:0] t_vj  [9];
  logic [31:0] t_vk  [9];
  logic [3:0]  t_rob [9];
  logic [31:0] t_res [9];
  logic        t_jmp [9];
  logic [31:0] t_pcn [9];

  rs_age_issue #(.DEPTH(16), .ROB_W(4), .CDB_NUM(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .rdy             (rdy),
    .dsp_valid       (dsp_valid),
    .dsp_ready       (dsp_ready),
    .dsp_op          (dsp_op),
    .dsp_pc          (dsp_pc),
    .dsp_imm         (dsp_imm),
    .dsp_vj          (dsp_vj),
    .dsp_vk          (dsp_vk),
    .dsp_qj          (dsp_qj),
    .dsp_qk          (dsp_qk),
    .dsp_rob         (dsp_rob),
    .cdb_in_valid    (cdb_in_valid),
    .cdb_in_rob      (cdb_in_rob),
    .cdb_in_value    (cdb_in_value),
    .cdb_out_valid   (cdb_out_valid),
    .cdb_out_rob     (cdb_out_rob),
    .cdb_out_value   (cdb_out_value),
    .cdb_out_jump    (cdb_out_jump),
    .cdb_out_pc_next (cdb_out_pc_next),
    .flush           (flush),
    .full            (full),
    .count           (count)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1, "watchdog");
  end

  // Driver tasks.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dsp(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] vj, input logic [31:0] vk,
                         input logic [3:0] qj, input logic [3:0] qk, input logic [3:0] rob);
    dsp_valid = 1'b1;
    dsp_op    = op;
    dsp_pc    = pc;
    dsp_imm   = imm;
    dsp_vj    = vj;
    dsp_vk    = vk;
    dsp_qj    = qj;
    dsp_qk    = qk;
    dsp_rob   = rob;
  endtask

  task automatic clr_dsp();
    dsp_valid = 1'b0;
    dsp_op    = '0;
    dsp_pc    = '0;
    dsp_imm   = '0;
    dsp_vj    = '0;
    dsp_vk    = '0;
    dsp_qj    = '0;
    dsp_qk    = '0;
    dsp_rob   = '0;
  endtask

  task automatic bcast(input int bus, input logic [3:0] tag, input logic [31:0] val);
    cdb_in_valid[bus]           = 1'b1;
    cdb_in_rob[bus*4 +: 4]      = tag;
    cdb_in_value[bus*32 +: 32]  = val;
  endtask

  task automatic clr_bus();
    cdb_in_valid = '0;
    cdb_in_rob   = '0;
    cdb_in_value = '0;
  endtask

  task automatic push_exp(input logic [3:0] rob, input logic [31:0] val,
                          input logic jmp, input logic [31:0] pcn);
    exp_q.push_back({rob, val, jmp, pcn});
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every result pulse must match the head of exp_q.
  always @(negedge clk) begin
    if (cdb_out_valid === 1'b1) begin
      mon_got = {cdb_out_rob, cdb_out_value, cdb_out_jump, cdb_out_pc_next};
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL cdb_out_unexpected: got rob=%0d value=%h jump=%0b pc_next=%h required no result",
                 cdb_out_rob, cdb_out_value, cdb_out_jump, cdb_out_pc_next);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          miscompares++;
          $display("FAIL cdb_out: got rob=%0d value=%h jump=%0b pc_next=%h required rob=%0d value=%h jump=%0b pc_next=%h",
                   mon_got[68:65], mon_got[64:33], mon_got[32], mon_got[31:0],
                   mon_exp[68:65], mon_exp[64:33], mon_exp[32], mon_exp[31:0]);
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst   = 1'b1;
    rdy   = 1'b1;
    flush = 1'b0;
    clr_dsp();
    clr_bus();

    t_op  = '{OP_SRA, OP_BLT, OP_JALR, OP_BGEU, OP_SUB, OP_LUI, OP_JAL, OP_SRAI, OP_AUIPC};
    t_pc  = '{32'h200, 32'h100, 32'h300, 32'h400, 32'h500, 32'h600, 32'h700, 32'h800, 32'h900};
    t_imm = '{32'h0, 32'h20, 32'h2, 32'h40, 32'h0, 32'h12345000, 32'h80, 32'd33, 32'h1000};
    t_vj  = '{32'h80000000, 32'hFFFFFFFF, 32'h1001, 32'h1, 32'h3, 32'h0, 32'h0, 32'h80000000, 32'h0};
    t_vk  = '{32'h4, 32'h1, 32'h0, 32'hFFFFFFFF, 32'h5, 32'h0, 32'h0, 32'h0, 32'h0};
    t_rob = '{4'd4, 4'd5, 4'd6, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14};
    t_res = '{32'hF8000000, 32'h0, 32'h304, 32'h0, 32'hFFFFFFFE, 32'h12345000, 32'h704, 32'hC0000000, 32'h1900};
    t_jmp = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    t_pcn = '{32'h204, 32'h120, 32'h1002, 32'h404, 32'h504, 32'h604, 32'h780, 32'h804, 32'h904};

    // Reset state.
    tick();
    tick();
    check("rst_valid", cdb_out_valid, 0);
    check("rst_rob", cdb_out_rob, 0);
    check("rst_value", cdb_out_value, 0);
    check("rst_jump", cdb_out_jump, 0);
    check("rst_pc_next", cdb_out_pc_next, 0);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_dsp_ready", dsp_ready, 1);
    rst = 1'b0;

    // ADDI 5+7 with no dependencies.
    set_dsp(OP_ADDI, 32'h1000, 32'd7, 32'd5, 32'd0, 4'd0, 4'd0, 4'd1);
    push_exp(4'd1, 32'd12, 1'b0, 32'h1004);
    tick();
    clr_dsp();
    check("addi_count_after_dispatch", count, 1);
    tick();
    check("addi_count_after_issue", count, 0);
    tick();

    // ADD waiting on tag 3, woken from cdb_in[1].
    set_dsp(OP_ADD, 32'h1010, 32'd0, 32'd0, 32'd1, 4'd3, 4'd0, 4'd2);
    push_exp(4'd2, 32'h11, 1'b0, 32'h1014);
    tick();
    clr_dsp();
    bcast(1, 4'd3, 32'h10);
    tick();
    clr_bus();
    check("wake_no_early_issue", cdb_out_valid, 0);
    tick();
    tick();
    check("wake_count_drained", count, 0);

    // Dispatch bypass from cdb_in[0].
    set_dsp(OP_ADD, 32'h1020, 32'd0, 32'd0, 32'd2, 4'd6, 4'd0, 4'd3);
    bcast(0, 4'd6, 32'h20);
    push_exp(4'd3, 32'h22, 1'b0, 32'h1024);
    tick();
    clr_dsp();
    clr_bus();
    tick();
    tick();

    // Self bypass on qk: cdb_out beats cdb_in[0] carrying the same tag.
    set_dsp(OP_ADDI, 32'h1030, 32'd1, 32'd1, 32'd0, 4'd0, 4'd0, 4'd7);
    push_exp(4'd7, 32'd2, 1'b0, 32'h1034);
    tick();
    clr_dsp();
    tick();
    set_dsp(OP_ADD, 32'h1040, 32'd0, 32'd3, 32'd0, 4'd0, 4'd7, 4'd8);
    bcast(0, 4'd7, 32'h999);
    push_exp(4'd8, 32'd5, 1'b0, 32'h1044);
    tick();
    clr_dsp();
    clr_bus();
    tick();
    tick();

    // ALU table back to back; dispatch and issue on the same edge keep count at 1.
    for (int k = 0; k < 9; k++) begin
      set_dsp(t_op[k], t_pc[k], t_imm[k], t_vj[k], t_vk[k], 4'd0, 4'd0, t_rob[k]);
      push_exp(t_rob[k], t_res[k], t_jmp[k], t_pcn[k]);
      tick();
      check("alu_count_steady", count, 1);
    end
    clr_dsp();
    tick();
    check("alu_count_drained", count, 0);
    tick();

    // Fill all 16 entries with ops waiting on tags.
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check("fill_ready_before_last", dsp_ready, 1);
      set_dsp(OP_ADD, 32'h2000 + 32'(4 * i), 32'd0, 32'd0, 32'(i),
              (i == 15) ? 4'd1 : 4'(i + 1), 4'd0, 4'((i % 15) + 1));
      tick();
    end
    clr_dsp();
    check("fill_full", full, 1);
    check("fill_dsp_ready", dsp_ready, 0);
    check("fill_count", count, 16);
    set_dsp(OP_ADDI, 32'h3000, 32'd1, 32'd1, 32'd0, 4'd0, 4'd0, 4'd9);
    tick();
    clr_dsp();
    check("full_refuse_count", count, 16);
    for (int i = 14; i >= 0; i--) begin
      push_exp(4'((i % 15) + 1), 32'h100 + 32'(i), 1'b0, 32'h2000 + 32'(4 * i) + 32'd4);
    end
    push_exp(4'd1, 32'h10F, 1'b0, 32'h2040);
    for (int t = 15; t >= 1; t--) begin
      bcast(0, 4'(t), 32'h100);
      if (t == 14) set_dsp(OP_ADDI, 32'h3000, 32'd1, 32'd1, 32'd0, 4'd0, 4'd0, 4'd9);
      tick();
      if (t == 14) begin
        clr_dsp();
        check("full_refuse_during_issue", count, 15);
      end
    end
    clr_bus();
    repeat (3) tick();
    check("reverse_wake_drained", count, 0);

    // Flush with 5 busy entries (one about to issue) and a simultaneous dispatch.
    for (int i = 0; i < 4; i++) begin
      set_dsp(OP_ADD, 32'h4000, 32'd0, 32'd0, 32'd1, 4'd12, 4'd0, 4'(i + 1));
      tick();
    end
    set_dsp(OP_ADDI, 32'h4100, 32'd1, 32'd1, 32'd0, 4'd0, 4'd0, 4'd5);
    tick();
    check("flush_pre_count", count, 5);
    set_dsp(OP_ADDI, 32'h4200, 32'd1, 32'd1, 32'd0, 4'd0, 4'd0, 4'd6);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    clr_dsp();
    check("flush_count", count, 0);
    check("flush_valid", cdb_out_valid, 0);
    bcast(0, 4'd12, 32'h77);
    tick();
    clr_bus();
    repeat (3) tick();
    check("flush_no_stale", count, 0);

    // rdy low for three cycles with a ready entry; dispatches are ignored.
    set_dsp(OP_ADDI, 32'hA00, 32'd2, 32'h40, 32'd0, 4'd0, 4'd0, 4'd3);
    push_exp(4'd3, 32'h42, 1'b0, 32'hA04);
    tick();
    set_dsp(OP_ADDI, 32'hA10, 32'd2, 32'h50, 32'd0, 4'd0, 4'd0, 4'd7);
    rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rdy_hold_valid", cdb_out_valid, 0);
      check("rdy_hold_count", count, 1);
    end
    clr_dsp();
    rdy = 1'b1;
    tick();
    check("rdy_resume_valid", cdb_out_valid, 1);
    check("rdy_resume_count", count, 0);
    tick();

    // Reset in the middle of operation.
    set_dsp(OP_ADD, 32'hB00, 32'd0, 32'd0, 32'd1, 4'd13, 4'd0, 4'd5);
    tick();
    set_dsp(OP_ADDI, 32'hB10, 32'd1, 32'd1, 32'd0, 4'd0, 4'd0, 4'd2);
    push_exp(4'd2, 32'd2, 1'b0, 32'hB14);
    tick();
    clr_dsp();
    tick();
    check("midrst_pre_count", count, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid", cdb_out_valid, 0);
    check("midrst_value", cdb_out_value, 0);
    check("midrst_rob", cdb_out_rob, 0);
    check("midrst_pc_next", cdb_out_pc_next, 0);
    check("midrst_count", count, 0);
    bcast(0, 4'd13, 32'h5);
    tick();
    clr_bus();
    repeat (3) tick();

    check("scoreboard_drained", 69'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rs_age_issue.md
# rs_age_issue

Parametrised reservation station for the out-of-order RISC-V core, sitting between the dispatcher and the CDB. It buffers `DEPTH` ALU/branch micro-ops and wakes operands from `CDB_NUM` broadcast buses plus its own output. Each cycle it issues the oldest ready entry through an internal ALU and drives the result onto its CDB port one cycle later. A mispredict flush empties it in one cycle.

## Interface
- `DEPTH`, 16: entry count, power of two, 2..32.
- `ROB_W`, 4: ROB tag width. Tag value 0 is reserved as "no dependency".
- `CDB_NUM`, 2: number of external CDB inputs (LSB, etc.).
- `clk` in 1: clock. Single clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `rdy` in 1: global enable. Low freezes all state and outputs.
- `dsp_valid` in 1: dispatch request.
- `dsp_ready` out 1: combinational, `!full`. A dispatch is accepted when `dsp_valid && dsp_ready && rdy`.
- `dsp_op` in 6: opcode (package enum).
- `dsp_pc`, `dsp_imm` in 32: instruction PC and immediate.
- `dsp_vj`, `dsp_vk` in 32: operand values.
- `dsp_qj`, `dsp_qk` in ROB_W: operand tags, 0 = value valid.
- `dsp_rob` in ROB_W: destination tag, never 0.
- `cdb_in_valid` in CDB_NUM: per-bus valid.
- `cdb_in_rob` in CDB_NUM*ROB_W: packed tags.
- `cdb_in_value` in CDB_NUM*32: packed values.
- `cdb_out_valid` out 1: result valid. Reset 0.
- `cdb_out_rob` out ROB_W: result tag. Reset 0.
- `cdb_out_value` out 32: result. Reset 0.
- `cdb_out_jump` out 1: branch/jump taken. Reset 0.
- `cdb_out_pc_next` out 32: resolved next PC. Reset 0.
- `flush` in 1: mispredict, clear everything.
- `full` out 1: combinational, occupancy == DEPTH.
- `count` out $clog2(DEPTH)+1: registered occupancy. Reset 0.

## Operation
- Entry fields: busy, op, pc, imm, vj, vk, qj, qk, rob. Age is held in a DEPTH×DEPTH age matrix, where bit [i][j] = 1 means entry i is older than entry j.
- **Allocation:** the lowest-index free entry is used. Its age row is set to 0 and its age column to 1 in all busy entries.
- **Dispatch bypass:** an incoming `qj` or `qk` that matches any valid CDB tag, including `cdb_out` in the same cycle, is stored as tag 0 with the bus value. `cdb_out` has priority over `cdb_in[0]`, which has priority over higher-indexed inputs.
- **Wake-up:** every busy entry compares qj and qk against all buses each cycle. On a match it latches the value and clears the tag.
- **Select:** an entry is ready when busy and qj == qk == 0. The block issues the ready entry that no other ready entry is older than. The issued entry's busy bit clears on the same edge.
- **ALU semantics:**
  - LUI: imm.
  - AUIPC: pc+imm.
  - JAL: result pc+4, pc_next pc+imm, jump=1.
  - JALR: result pc+4, pc_next (vj+imm)&~1, jump=1.
  - Branches (BEQ/BNE/BLT/BGE/BLTU/BGEU): signed or unsigned compare. jump = condition; pc_next = jump ? pc+imm : pc+4; result 0.
  - Other ops (SLL/SRL/SRA and immediate forms): shift amount is the low 5 bits. SRA/SRAI are arithmetic.
  - Non-jump ops: jump=0, pc_next=pc+4.
- **Flush:** all busy bits clear, `count` goes to 0, `cdb_out_valid` goes to 0 next edge. Dispatch and issue in the same cycle are discarded.

## Timing
- Dispatch at edge n: the entry is visible at n. It may issue at edge n+1 if its operands are ready or bypassed.
- CDB wake at edge n makes the entry eligible at edge n+1. Issue at edge n puts the result on `cdb_out` during cycle n..n+1; the pulse lasts one cycle unless another issue follows.
- Back-to-back issue every cycle is supported. Result-to-dependent latency is 1 cycle via the self bypass.
- **Full:** `full` is computed from the pre-edge state. A dispatch while full is refused even if an issue frees an entry on the same edge.
- **Simultaneous dispatch and issue:** `count` is unchanged.
- **Priority:** `rst` > `!rdy` > `flush` > normal. `rst` mid-operation clears all outputs to their reset values.

## Structure
- A shared package (`rs_pkg`) holds the opcode enum, `NON_DEP = 0`, and the operand-record typedef.
- Sub-module `rs_alu`: purely combinational, taking op/pc/imm/vj/vk and producing result/jump/pc_next. It is reused by later execution units.

## Test plan
- Dispatch ADDI vj=5 imm=7 with no deps -> one cycle later `cdb_out` shows value 12 with its rob tag, and `count` returns to 0.
- Dispatch ADD qj=3 (tag 3 on `cdb_in[1]` value 0x10 one cycle later), vk=1 -> result 0x11 two cycles after the broadcast.
- Fill all 16 entries with tag-waiting ops -> `full`=1 and `dsp_ready`=0. A 17th dispatch is ignored. Waking tags in reverse order -> issue follows wake order, and the oldest wins when several become ready together.
- SRA vj=0x80000000 vk=4 -> 0xF8000000. BLT vj=-1 vk=1 pc=0x100 imm=0x20 -> jump=1, pc_next 0x120.
- Assert `flush` with 5 busy entries and a simultaneous dispatch -> next cycle `count`=0 and `cdb_out_valid`=0, and no stale result appears later.
- Hold `rdy`=0 for 3 cycles with a ready entry -> no issue and outputs held. Issue occurs on the first edge with `rdy`=1.
